core_csr_trap_unit: RTL and testbench
=====================================

# core_csr_trap_unit

Machine-mode CSR file and trap sequencer that consumes the decoded ecall/ebreak/mret/sret/CSR/illegal flags from the CSR control decoder in the execute stage. It performs Zicsr read-modify-write accesses and takes exceptions, external interrupts and `mret`. Each control transfer is issued to fetch as a single registered redirect under a valid/ready handshake. Two privilege levels are supported: M and U; S-mode is not implemented.

## Interface
- `RESET_MTVEC`, 32'h0000_0000: reset value of `mtvec`; mode bits are forced to 00.
- `HART_ID`, 0: value returned by `mhartid`.
- `i_clk`  in  1  core clock; everything is synchronous to its rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  instruction in the execute stage that would retire this cycle.
- `i_pc`  in  32  PC of that instruction.
- `i_instr`  in  32  raw instruction; supplies csr addr [31:20], funct3 [14:12], rs1/zimm [19:15].
- `i_rs1_data`  in  32  rs1 operand.
- `i_ecall`, `i_ebreak`, `i_mret`, `i_sret`, `i_csr_wen`, `i_illegal`  in  1 each  decoder flags.
- `i_irq_ext`  in  1  machine external interrupt, level-sensitive.
- `i_redirect_ready`  in  1  fetch accepts the redirect.
- `o_csr_rdata`  out  32  old CSR value for the rd writeback; combinational.
- `o_stall`  out  1  hold the upstream pipeline.
- `o_flush`  out  1  kill younger instructions; equals `o_redirect_valid`.
- `o_redirect_valid`  out  1  redirect request.
- `o_redirect_pc`  out  32  redirect target.
- `o_priv_m`  out  1  current privilege is M.

## Operation
- **Implemented CSRs**
  - `mstatus` 0x300: MIE[3], MPIE[7], MPP[12:11] (WARL: 00 or 11).
  - `mie` 0x304: MEIE[11].
  - `mip` 0x344: MEIP[11]; read-only, reflects `i_irq_ext`.
  - `mtvec` 0x305: mode[1:0] WARL; a write of 1x stores 00.
  - `mscratch` 0x340.
  - `mepc` 0x341: [1:0] always read as 0.
  - `mcause` 0x342 and `mtval` 0x343.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82.
  - `mhartid` 0xF14: read-only.
- **CSR ops by funct3**
  - 001 RW, 010 RS, 011 RC.
  - 101/110/111: same ops with zimm zero-extended.
  - RS/RC with rs1/zimm field = 0 perform no write and never fault on write.
- **Illegal conditions**, in addition to `i_illegal`:
  - address not implemented;
  - addr[9:8] = 11 while in U;
  - addr[11:10] = 11 with write intent;
  - `i_sret` at any privilege;
  - `i_mret` in U.
- **Event priority** for a valid instruction in IDLE:
  1. Interrupt, taken when MIE & MEIE & `i_irq_ext`: mcause 0x8000000B, mtval 0, the instruction does not execute.
  2. Illegal: mcause 2, mtval = `i_instr`.
  3. ecall: mcause 8 from U, 11 from M; mtval 0.
  4. ebreak: mcause 3, mtval = `i_pc`.
  5. mret.
  6. CSR op.
- **Trap entry**
  - mepc ← `i_pc`; MPIE ← MIE; MIE ← 0; MPP ← current privilege; privilege ← M.
  - Target is mtvec base; for interrupts in vectored mode it is base + 4·cause[4:0].
- **mret**
  - MIE ← MPIE; MPIE ← 1; privilege ← MPP; MPP ← 00.
  - Target is `mepc`.
- **Counters**
  - `mcycle` increments every cycle.
  - `minstret` increments when `i_valid` and the instruction retires without trapping.
  - A CSR write to either half takes precedence over that cycle's increment.
  - The low half wraps into the high half as one 64-bit value.

## Timing
- **FSM**: IDLE and REDIR.
  - IDLE → REDIR on a trap or mret accepted in cycle N.
  - REDIR → IDLE in the cycle where `i_redirect_ready` = 1.
- **Cycle N** (event accepted in IDLE):
  - `o_stall` = 1, combinational.
  - All CSR and privilege updates, plus the latched target, commit at the end of N.
- **Cycles N+1 onward**: `o_redirect_valid` = `o_flush` = 1 and `o_stall` = 1 with a stable `o_redirect_pc` until ready is seen. Minimum redirect latency is 1 cycle.
- **While in REDIR**: `i_valid` and every flag are ignored, no CSR writes occur, and counters keep running.
- **CSR ops**: `o_csr_rdata` is valid in the same cycle; the write commits at the cycle end; no stall.
- **`i_irq_ext` rising during REDIR**: sampled in the first IDLE cycle that has `i_valid`.
- **Reset** (including mid-REDIR):
  - state IDLE; privilege M; mstatus 0; mtvec = `RESET_MTVEC`; all other CSRs and counters 0.
  - outputs 0, except `o_priv_m` = 1.

## Structure
- Package `core_csr_pkg`:
  - CSR address localparams;
  - cause code constants;
  - `priv_e` {U=2'b00, M=2'b11};
  - `trap_state_e` {IDLE, REDIR};
  - mstatus bit-index localparams.
- Sub-module `core_csr_counter64`: 64-bit counter with an increment enable and independent lo/hi write ports. It is instantiated twice, for mcycle and minstret.

## Test plan
- **Write then read mtvec**: in M, CSRRW 0x305 with rs1 = 0x80000101 → `o_csr_rdata` = old value; a later read returns 0x80000101.
- **ecall from U**: set MPP = 00, mret, then `i_ecall` at pc 0x100 → the next cycle shows `o_redirect_valid` = 1 and `o_redirect_pc` = mtvec base; afterwards mepc = 0x100, mcause = 8, `o_priv_m` = 1.
- **Vectored interrupt**: mtvec = 0x1001, MIE = 1, MEIE = 1, `i_irq_ext` = 1 → redirect to 0x102C with mcause 0x8000000B; an illegal instruction issued in the same cycle is not reported.
- **Handshake hold**: trap with `i_redirect_ready` low for 3 cycles → redirect valid, pc stable and stall held for all 3 cycles; return to IDLE one cycle after ready.
- **U-mode access faults**: CSRRS to 0x300 in U → mcause 2, mtval = instr. CSRRW to 0xF14 in M → illegal. CSRRS to 0xF14 with rs1 = x0 → legal read of `HART_ID`.
- **Counter boundary and reset**: mcycle = 0xFFFFFFFF → next cycle mcycle = 0 and mcycleh = 1. Assert `i_rst` during REDIR → all outputs 0, `o_priv_m` = 1, mtvec = `RESET_MTVEC`.

Source files
------------

// File: rtl/core_csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer.
// Holds CSR addresses, cause codes, mstatus bit positions and state enums.
package core_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;
    localparam int MIE_MEIE   = 11;
    localparam int MIP_MEIP   = 11;

    typedef enum logic [1:0] {
        U = 2'b00,
        M = 2'b11
    } priv_e;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } trap_state_e;

    function automatic logic csr_exists(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MTVAL, CSR_MIP, CSR_MCYCLE,
            CSR_MINSTRET, CSR_MCYCLEH,
            CSR_MINSTRETH, CSR_MHARTID:
                csr_exists = 1'b1;
            default:
                csr_exists = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_csr_trap_unit_counter64.sv
// 64-bit free-running counter with separate low/high write ports.
// A write to either half wins over the increment in that cycle.
module core_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // count up, or load one/both halves from a CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/core_csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the execute stage.
// Traps and mret are issued to fetch as one registered redirect.
module core_csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs1_data,
    input  logic        i_ecall,
    input  logic        i_ebreak,
    input  logic        i_mret,
    input  logic        i_sret,
    input  logic        i_csr_wen,
    input  logic        i_illegal,
    input  logic        i_irq_ext,
    input  logic        i_redirect_ready,
    output logic [31:0] o_csr_rdata,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_priv_m
);

    import core_csr_pkg::*;

    trap_state_e state, state_nxt;
    priv_e       priv;
    priv_e       mpp_r;
    logic        mie_r;
    logic        mpie_r;
    logic        meie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] mtval_r;
    logic [31:0] redir_pc_r;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [11:0] csr_addr;
    logic [2:0]  funct3;
    logic [4:0]  rs1_f;
    logic [31:0] csr_opnd;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic [31:0] mstatus_rd;
    logic        wr_intent;
    logic        csr_bad;
    logic        illegal;
    logic        accept;
    logic        irq_pend;
    logic        ok0, ok1, ok2, ok3, ok4;
    logic        take_irq, take_ill;
    logic        take_ecall, take_ebrk;
    logic        take_mret, do_csr;
    logic        trap, event_go;
    logic        csr_we, retire;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic [31:0] tvec_base;
    logic [31:0] trap_target;
    logic        unused_instr;

    assign csr_addr = i_instr[31:20];
    assign rs1_f    = i_instr[19:15];
    assign funct3   = i_instr[14:12];
    assign unused_instr = ^i_instr[11:0];

    assign csr_opnd = funct3[2] ? {27'd0, rs1_f}
                                : i_rs1_data;

    // RW always writes; RS/RC only with a nonzero source
    assign wr_intent = (funct3[1:0] == 2'b01)
                     | (funct3[1] & (rs1_f != 5'd0));

    assign csr_bad = i_csr_wen & (
          ~csr_exists(csr_addr)
        | ((csr_addr[9:8] == 2'b11) & (priv == U))
        | ((csr_addr[11:10] == 2'b11) & wr_intent));

    assign illegal = i_illegal | csr_bad | i_sret
                   | (i_mret & (priv == U));

    assign accept   = (state == IDLE) & i_valid;
    assign irq_pend = mie_r & meie_r & i_irq_ext;

    assign ok0 = accept & ~irq_pend;
    assign ok1 = ok0 & ~illegal;
    assign ok2 = ok1 & ~i_ecall;
    assign ok3 = ok2 & ~i_ebreak;
    assign ok4 = ok3 & ~i_mret;

    assign take_irq   = accept & irq_pend;
    assign take_ill   = ok0 & illegal;
    assign take_ecall = ok1 & i_ecall;
    assign take_ebrk  = ok2 & i_ebreak;
    assign take_mret  = ok3 & i_mret;
    assign do_csr     = ok4 & i_csr_wen;

    assign trap     = take_irq | take_ill
                    | take_ecall | take_ebrk;
    assign event_go = trap | take_mret;
    assign csr_we   = do_csr & wr_intent;
    assign retire   = accept & ~trap;

    assign mstatus_rd = {19'd0, mpp_r, 3'd0, mpie_r,
                         3'd0, mie_r, 3'd0};

    // cause and trap value for the winning exception
    always_comb begin
        trap_cause = '0;
        trap_tval  = '0;
        unique case (1'b1)
            take_irq: trap_cause = CAUSE_MEI;
            take_ill: begin
                trap_cause = CAUSE_ILLEGAL;
                trap_tval  = i_instr;
            end
            take_ecall: trap_cause = (priv == M)
                        ? CAUSE_ECALL_M : CAUSE_ECALL_U;
            take_ebrk: begin
                trap_cause = CAUSE_BREAK;
                trap_tval  = i_pc;
            end
            default: ;
        endcase
    end

    // redirect target: mepc, mtvec base or vectored slot
    always_comb begin
        tvec_base   = {mtvec_r[31:2], 2'b00};
        trap_target = tvec_base;
        if (take_mret) begin
            trap_target = mepc_r;
        end else if (take_irq && mtvec_r[1:0] == 2'b01) begin
            trap_target = tvec_base
                        + {25'd0, trap_cause[4:0], 2'b00};
        end
    end

    // CSR read mux returning the pre-write value
    always_comb begin
        csr_old = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_old = mstatus_rd;
            CSR_MIE:       csr_old[MIE_MEIE] = meie_r;
            CSR_MIP:       csr_old[MIP_MEIP] = i_irq_ext;
            CSR_MTVEC:     csr_old = mtvec_r;
            CSR_MSCRATCH:  csr_old = mscratch_r;
            CSR_MEPC:      csr_old = mepc_r;
            CSR_MCAUSE:    csr_old = mcause_r;
            CSR_MTVAL:     csr_old = mtval_r;
            CSR_MCYCLE:    csr_old = mcycle[31:0];
            CSR_MCYCLEH:   csr_old = mcycle[63:32];
            CSR_MINSTRET:  csr_old = minstret[31:0];
            CSR_MINSTRETH: csr_old = minstret[63:32];
            CSR_MHARTID:   csr_old = HART_ID;
            default:       csr_old = '0;
        endcase
    end

    // read-modify-write result for RW/RS/RC
    always_comb begin
        csr_new = csr_old;
        case (funct3[1:0])
            2'b01:   csr_new = csr_opnd;
            2'b10:   csr_new = csr_old | csr_opnd;
            2'b11:   csr_new = csr_old & ~csr_opnd;
            default: csr_new = csr_old;
        endcase
    end

    assign o_csr_rdata = i_csr_wen ? csr_old : '0;

    // privilege, mstatus and trap CSRs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            priv       <= M;
            mpp_r      <= U;
            mie_r      <= 1'b0;
            mpie_r     <= 1'b0;
            meie_r     <= 1'b0;
            mtvec_r    <= {RESET_MTVEC[31:2], 2'b00};
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
        end else if (trap) begin
            mepc_r   <= {i_pc[31:2], 2'b00};
            mcause_r <= trap_cause;
            mtval_r  <= trap_tval;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
            mpp_r    <= priv;
            priv     <= M;
        end else if (take_mret) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
            priv   <= mpp_r;
            mpp_r  <= U;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_r  <= csr_new[MST_MIE];
                    mpie_r <= csr_new[MST_MPIE];
                    mpp_r  <= (csr_new[MST_MPP_HI:MST_MPP_LO]
                               == 2'b11) ? M : U;
                end
                CSR_MIE:      meie_r <= csr_new[MIE_MEIE];
                CSR_MTVEC:    mtvec_r <= {csr_new[31:2],
                                  csr_new[1] ? 2'b00
                                             : csr_new[1:0]};
                CSR_MSCRATCH: mscratch_r <= csr_new;
                CSR_MEPC:     mepc_r <= {csr_new[31:2], 2'b00};
                CSR_MCAUSE:   mcause_r <= csr_new;
                CSR_MTVAL:    mtval_r <= csr_new;
                default: ;
            endcase
        end
    end

    core_csr_counter64 u_mcycle (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (1'b1),
        .wr_lo (csr_we & (csr_addr == CSR_MCYCLE)),
        .wr_hi (csr_we & (csr_addr == CSR_MCYCLEH)),
        .wdata (csr_new),
        .count (mcycle)
    );

    core_csr_counter64 u_minstret (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (retire),
        .wr_lo (csr_we & (csr_addr == CSR_MINSTRET)),
        .wr_hi (csr_we & (csr_addr == CSR_MINSTRETH)),
        .wdata (csr_new),
        .count (minstret)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (event_go) state_nxt = REDIR;
            REDIR: if (i_redirect_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // latched redirect target, stable while in REDIR
    always_ff @(posedge i_clk) begin
        if (i_rst)         redir_pc_r <= '0;
        else if (event_go) redir_pc_r <= trap_target;
    end

    // FSM outputs
    always_comb begin
        o_redirect_valid = (state == REDIR);
        o_flush          = (state == REDIR);
        o_stall          = (state == REDIR) | event_go;
        o_redirect_pc    = redir_pc_r;
        o_priv_m         = (priv == M);
    end

endmodule

// File: tb/tb_core_csr_trap_unit.sv
// Directed bench for core_csr_trap_unit: vector table plus
// hand sequences for handshake hold, counters and reset.
module tb_core_csr_trap_unit;

    localparam logic [5:0] F_ECALL = 6'b100000;
    localparam logic [5:0] F_EBRK  = 6'b010000;
    localparam logic [5:0] F_MRET  = 6'b001000;
    localparam logic [5:0] F_SRET  = 6'b000100;
    localparam logic [5:0] F_CSR   = 6'b000010;
    localparam logic [5:0] F_ILL   = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_pc, i_instr, i_rs1_data;
    logic        i_ecall, i_ebreak, i_mret;
    logic        i_sret, i_csr_wen, i_illegal;
    logic        i_irq_ext, i_redirect_ready;
    logic [31:0] o_csr_rdata;
    logic        o_stall, o_flush, o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_priv_m;

    int errors = 0;
    int checks = 0;

    core_csr_trap_unit #(
        .RESET_MTVEC (32'h0000_0400),
        .HART_ID     (32'd5)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (i_valid),
        .i_pc             (i_pc),
        .i_instr          (i_instr),
        .i_rs1_data       (i_rs1_data),
        .i_ecall          (i_ecall),
        .i_ebreak         (i_ebreak),
        .i_mret           (i_mret),
        .i_sret           (i_sret),
        .i_csr_wen        (i_csr_wen),
        .i_illegal        (i_illegal),
        .i_irq_ext        (i_irq_ext),
        .i_redirect_ready (i_redirect_ready),
        .o_csr_rdata      (o_csr_rdata),
        .o_stall          (o_stall),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_priv_m         (o_priv_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [5:0]  fl;
        logic        irq;
        logic        ck;
        logic [31:0] e_rd;
        logic        e_st;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_pm;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] ci(input logic [2:0] f3,
                                       input logic [11:0] a,
                                       input logic [4:0] r);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    function automatic vec_t mk(input logic vld,
        input logic [31:0] ins, rs1, pc, input logic [5:0] fl,
        input logic irq, ck, input logic [31:0] erd,
        input logic st, rv, input logic [31:0] epc,
        input logic pm);
        vec_t v;
        v.vld = vld; v.ins = ins; v.rs1 = rs1; v.pc = pc;
        v.fl = fl; v.irq = irq; v.ck = ck; v.e_rd = erd;
        v.e_st = st; v.e_rv = rv; v.e_pc = epc; v.e_pm = pm;
        return v;
    endfunction

    function automatic vec_t rd(input logic [11:0] a,
                                input logic [31:0] e);
        return mk(1, ci(3'b010, a, 0), 0, 32'h10, F_CSR, 0,
                  1, e, 0, 0, 0, 1);
    endfunction

    function automatic vec_t wr(input logic [2:0] f3,
        input logic [11:0] a, input logic [4:0] r,
        input logic [31:0] d, input logic [31:0] e);
        return mk(1, ci(f3, a, r), d, 32'h14, F_CSR, 0,
                  1, e, 0, 0, 0, 1);
    endfunction

    function automatic vec_t ev(input logic [5:0] fl,
        input logic [31:0] pc, ins, input logic irq,
        input logic pm);
        return mk(1, ins, 0, pc, fl, irq, 0, 0, 1, 0, 0, pm);
    endfunction

    function automatic vec_t rdr(input logic [31:0] epc,
                                 input logic pm);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, epc, pm);
    endfunction

    task automatic drive(input logic vld,
        input logic [31:0] ins, rs1, pc, input logic [5:0] fl,
        input logic irq, rdy);
        i_valid = vld; i_instr = ins; i_rs1_data = rs1;
        i_pc = pc; i_irq_ext = irq; i_redirect_ready = rdy;
        {i_ecall, i_ebreak, i_mret,
         i_sret, i_csr_wen, i_illegal} = fl;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic chk_out(input string t, input logic st, rv,
                           input logic [31:0] pc,
                           input logic pm);
        chk({t, " stall"}, 32'(o_stall), 32'(st));
        chk({t, " rvalid"}, 32'(o_redirect_valid), 32'(rv));
        chk({t, " flush"}, 32'(o_flush), 32'(rv));
        chk({t, " priv_m"}, 32'(o_priv_m), 32'(pm));
        if (rv) chk({t, " rpc"}, o_redirect_pc, pc);
    endtask

    task automatic cyc(input logic vld, input logic [31:0] ins,
        rs1, pc, input logic [5:0] fl, input logic irq, rdy);
        @(negedge clk);
        drive(vld, ins, rs1, pc, fl, irq, rdy);
        #1;
    endtask

    task automatic rdchk(input string t, input logic [11:0] a,
                         input logic [31:0] e);
        cyc(1, ci(3'b010, a, 0), 0, 32'h20, F_CSR, 0, 1);
        chk(t, o_csr_rdata, e);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 1);
        chk("reset rpc", o_redirect_pc, 32'h0);
        chk("reset rdata", o_csr_rdata, 32'h0);
        rst = 1'b0;

        tbl.push_back(wr(3'b001, 12'h305, 1, 32'h8000_0101,
                         32'h400));
        tbl.push_back(rd(12'h305, 32'h8000_0101));
        tbl.push_back(ev(F_MRET, 32'h40, 0, 0, 1));
        tbl.push_back(rdr(32'h0, 0));
        tbl.push_back(ev(F_ECALL, 32'h100, 0, 0, 0));
        tbl.push_back(rdr(32'h8000_0100, 1));
        tbl.push_back(rd(12'h341, 32'h100));
        tbl.push_back(rd(12'h342, 32'd8));
        tbl.push_back(rd(12'h300, 32'h0));
        tbl.push_back(ev(F_MRET, 32'h44, 0, 0, 1));
        tbl.push_back(rdr(32'h100, 0));
        tbl.push_back(ev(F_CSR, 32'h104, 32'h3000_20F3, 0, 0));
        tbl.push_back(rdr(32'h8000_0100, 1));
        tbl.push_back(rd(12'h342, 32'd2));
        tbl.push_back(rd(12'h343, 32'h3000_20F3));
        tbl.push_back(ev(F_CSR, 32'h200, 32'hF141_10F3, 0, 1));
        tbl.push_back(rdr(32'h8000_0100, 1));
        tbl.push_back(rd(12'hF14, 32'd5));
        tbl.push_back(rd(12'h342, 32'd2));
        tbl.push_back(wr(3'b001, 12'h305, 1, 32'h1001,
                         32'h8000_0101));
        tbl.push_back(wr(3'b010, 12'h304, 2, 32'h800, 32'h0));
        tbl.push_back(wr(3'b110, 12'h300, 8, 32'h0, 32'h1800));
        tbl.push_back(ev(F_ILL, 32'h300, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(rdr(32'h102C, 1));
        tbl.push_back(rd(12'h342, 32'h8000_000B));
        tbl.push_back(rd(12'h300, 32'h1880));
        tbl.push_back(rd(12'h343, 32'h0));
        tbl.push_back(mk(1, ci(3'b010, 12'h344, 0), 0, 32'h18,
                         F_CSR, 1, 1, 32'h800, 0, 0, 0, 1));
        tbl.push_back(ev(F_SRET, 32'h400, 0, 0, 1));
        tbl.push_back(rdr(32'h1000, 1));
        tbl.push_back(rd(12'h342, 32'd2));
        tbl.push_back(ev(F_CSR, 32'h404, 32'h7C00_20F3, 0, 1));
        tbl.push_back(rdr(32'h1000, 1));
        tbl.push_back(ev(F_EBRK, 32'h556, 0, 0, 1));
        tbl.push_back(rdr(32'h1000, 1));
        tbl.push_back(rd(12'h343, 32'h556));
        tbl.push_back(rd(12'h342, 32'd3));
        tbl.push_back(rd(12'h341, 32'h554));

        foreach (tbl[i]) begin
            cyc(tbl[i].vld, tbl[i].ins, tbl[i].rs1, tbl[i].pc,
                tbl[i].fl, tbl[i].irq, 1'b1);
            if (tbl[i].ck)
                chk($sformatf("v%0d rdata", i),
                    o_csr_rdata, tbl[i].e_rd);
            chk_out($sformatf("v%0d", i), tbl[i].e_st,
                    tbl[i].e_rv, tbl[i].e_pc, tbl[i].e_pm);
        end

        cyc(1, 0, 0, 32'h600, F_ECALL, 0, 0);
        chk_out("hold ev", 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 1)
                cyc(1, ci(3'b001, 12'h340, 1), 32'hDEAD,
                    32'h604, F_CSR, 0, 0);
            else
                cyc(0, 0, 0, 0, 0, 0, 0);
            chk_out($sformatf("hold%0d", k), 1, 1, 32'h1000, 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_out("hold rdy", 1, 1, 32'h1000, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_out("hold idle", 0, 0, 0, 1);
        rdchk("hold mscratch", 12'h340, 32'h0);
        rdchk("hold mcause", 12'h342, 32'd11);

        cyc(1, ci(3'b001, 12'hB00, 1), 32'hFFFF_FFFF,
            32'h700, F_CSR, 0, 1);
        rdchk("mcycle max", 12'hB00, 32'hFFFF_FFFF);
        rdchk("mcycle wrap", 12'hB00, 32'h0);
        rdchk("mcycleh carry", 12'hB80, 32'd1);

        cyc(1, ci(3'b001, 12'hB02, 1), 32'h0,
            32'h710, F_CSR, 0, 1);
        rdchk("minstret wr", 12'hB02, 32'd0);
        rdchk("minstret inc", 12'hB02, 32'd1);
        cyc(1, 0, 0, 32'h720, F_ECALL, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        rdchk("minstret trap", 12'hB02, 32'd2);

        cyc(1, 0, 0, 32'h800, F_ECALL, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk_out("pre-rst redir", 1, 1, 32'h1000, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_out("rst redir", 0, 0, 0, 1);
        chk("rst rpc", o_redirect_pc, 32'h0);
        rst = 1'b0;
        rdchk("rst mtvec", 12'h305, 32'h400);
        rdchk("rst mstatus", 12'h300, 32'h0);
        rdchk("rst mcause", 12'h342, 32'h0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
